// File: rtl/ppu_vram_responder.sv
// VRAM/OAM responder: one-cycle PPU fetch port, mode-locked CPU port,
// and the OAM DMA engine started by a write to the DMA register.
module ppu_vram_responder #(
    parameter logic [15:0] VRAM_BASE = 16'h8000,
    parameter logic [15:0] OAM_BASE  = 16'hFE00,
    parameter logic [15:0] DMA_REG   = 16'hFF46,
    parameter int          DMA_LEN   = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_on,
    input  logic [1:0]  ppu_mode,
    input  logic [15:0] ppu_addr,
    output logic [7:0]  ppu_rdata,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        dma_src_rd,
    output logic [15:0] dma_src_addr,
    input  logic [7:0]  dma_src_data,
    output logic        dma_active
);

    localparam int VRAM_SIZE = 8192;
    localparam int OAM_SIZE  = 160;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [7:0] LEN = 8'(DMA_LEN);

    logic [7:0] vram [VRAM_SIZE];
    logic [7:0] oam  [OAM_SIZE];

    logic [0:0] state;
    logic [7:0] idx;
    logic [7:0] src_hi;

    logic [15:0] p_voff;
    logic [15:0] p_ooff;
    logic [15:0] c_voff;
    logic [15:0] c_ooff;
    logic        p_in_vram;
    logic        p_in_oam;
    logic        c_in_vram;
    logic        c_in_oam;
    logic        vram_lock;
    logic        oam_lock;
    logic        cpu_vram_we;
    logic        cpu_oam_we;
    logic        dma_start;
    logic        dma_wr;
    logic [7:0]  dma_widx;

    assign p_voff = ppu_addr - VRAM_BASE;
    assign p_ooff = ppu_addr - OAM_BASE;
    assign c_voff = cpu_addr - VRAM_BASE;
    assign c_ooff = cpu_addr - OAM_BASE;

    assign p_in_vram = p_voff < 16'(VRAM_SIZE);
    assign p_in_oam  = p_ooff < 16'(OAM_SIZE);
    assign c_in_vram = c_voff < 16'(VRAM_SIZE);
    assign c_in_oam  = c_ooff < 16'(OAM_SIZE);

    assign dma_active = (state == S_RUN);

    assign vram_lock = lcd_on && (ppu_mode == 2'd3);
    assign oam_lock  = dma_active || (lcd_on && ppu_mode[1]);

    assign cpu_vram_we = cpu_wr && c_in_vram && !vram_lock;
    assign cpu_oam_we  = cpu_wr && c_in_oam && !oam_lock;
    assign dma_start   = cpu_wr && (cpu_addr == DMA_REG);

    // Source data arrives one cycle after its address, so index i lands in i-1.
    assign dma_wr   = dma_active && (idx != 8'd0);
    assign dma_widx = idx - 8'd1;

    assign dma_src_rd   = dma_active && (idx < LEN);
    assign dma_src_addr = dma_src_rd ? {src_hi, idx} : 16'h0000;

    // Arrays are not reset; CPU OAM writes can never coincide with DMA.
    always_ff @(posedge clk) begin
        if (cpu_vram_we) begin
            vram[c_voff[12:0]] <= cpu_wdata;
        end
        if (dma_wr) begin
            oam[dma_widx] <= dma_src_data;
        end else if (cpu_oam_we) begin
            oam[c_ooff[7:0]] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ppu_rdata <= 8'hFF;
            cpu_rdata <= 8'hFF;
        end else begin
            if (p_in_vram) begin
                ppu_rdata <= vram[p_voff[12:0]];
            end else if (p_in_oam && !dma_active) begin
                ppu_rdata <= oam[p_ooff[7:0]];
            end else begin
                ppu_rdata <= 8'hFF;
            end
            if (cpu_rd) begin
                if (c_in_vram && !vram_lock) begin
                    cpu_rdata <= vram[c_voff[12:0]];
                end else if (c_in_oam && !oam_lock) begin
                    cpu_rdata <= oam[c_ooff[7:0]];
                end else begin
                    cpu_rdata <= 8'hFF;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            idx    <= 8'd0;
            src_hi <= 8'd0;
        end else if (dma_start) begin
            state  <= S_RUN;
            idx    <= 8'd0;
            src_hi <= cpu_wdata;
        end else if (state == S_RUN) begin
            if (idx == LEN) begin
                state <= S_IDLE;
            end
            if (idx != 8'hFF) begin
                idx <= idx + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ppu_vram_responder.sv
// Randomized self-checking bench for ppu_vram_responder against an
// array-based reference model of VRAM, OAM and the DMA source.
module tb_ppu_vram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        lcd_on;
    logic [1:0]  ppu_mode;
    logic [15:0] ppu_addr;
    logic [7:0]  ppu_rdata;
    logic [15:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        dma_src_rd;
    logic [15:0] dma_src_addr;
    logic [7:0]  dma_src_data;
    logic        dma_active;

    int tests = 0;
    int fails = 0;

    logic [7:0] vm [8192];
    logic [7:0] om [160];

    ppu_vram_responder dut (
        .clk          (clk),
        .rst          (rst),
        .lcd_on       (lcd_on),
        .ppu_mode     (ppu_mode),
        .ppu_addr     (ppu_addr),
        .ppu_rdata    (ppu_rdata),
        .cpu_addr     (cpu_addr),
        .cpu_rd       (cpu_rd),
        .cpu_wr       (cpu_wr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .dma_src_rd   (dma_src_rd),
        .dma_src_addr (dma_src_addr),
        .dma_src_data (dma_src_data),
        .dma_active   (dma_active)
    );

    always #5 clk = ~clk;

    // System bus model: data for last cycle's address is low byte ^ 0xA5.
    always @(posedge clk) dma_src_data <= dma_src_addr[7:0] ^ 8'hA5;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_cpu(input logic [15:0] a,
                                             input logic lcd,
                                             input logic [1:0] m);
        int off;
        off = int'(a) - 32'h8000;
        if (off >= 0 && off < 8192)
            return (lcd && m == 2'd3) ? 8'hFF : vm[off];
        off = int'(a) - 32'hFE00;
        if (off >= 0 && off < 160)
            return (lcd && m >= 2'd2) ? 8'hFF : om[off];
        return 8'hFF;
    endfunction

    function automatic logic [7:0] model_ppu(input logic [15:0] a);
        int off;
        off = int'(a) - 32'h8000;
        if (off >= 0 && off < 8192) return vm[off];
        off = int'(a) - 32'hFE00;
        if (off >= 0 && off < 160) return om[off];
        return 8'hFF;
    endfunction

    function automatic logic [15:0] pick_addr();
        logic [15:0] odd [5];
        odd[0] = 16'hFEA0;
        odd[1] = 16'hFEFF;
        odd[2] = 16'hA000;
        odd[3] = 16'h7FFF;
        odd[4] = 16'hFF80;
        case ($urandom_range(0, 3))
            0: return 16'h8000 + 16'($urandom_range(0, 63));
            1: return 16'h9FC0 + 16'($urandom_range(0, 63));
            2: return 16'hFE00 + 16'($urandom_range(0, 159));
            default: return odd[$urandom_range(0, 4)];
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        lcd_on = 1'b0;
        ppu_mode = 2'd0;
        ppu_addr = 16'h0000;
        cpu_addr = 16'h0000;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        cpu_wdata = 8'h00;
        tick();
        tick();
        tests++;
        if (ppu_rdata !== 8'hFF) begin
            fails++;
            $display("FAIL reset_ppu_rdata got %h want ff", ppu_rdata);
        end
        tests++;
        if (cpu_rdata !== 8'hFF) begin
            fails++;
            $display("FAIL reset_cpu_rdata got %h want ff", cpu_rdata);
        end
        tests++;
        if (dma_active !== 1'b0 || dma_src_rd !== 1'b0) begin
            fails++;
            $display("FAIL reset_dma got act=%b rd=%b want 0 0",
                     dma_active, dma_src_rd);
        end
        tests++;
        if (dma_src_addr !== 16'h0000) begin
            fails++;
            $display("FAIL reset_src_addr got %h want 0000", dma_src_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_vram_rw();
        lcd_on = 1'b0;
        cpu_addr = 16'h8010;
        cpu_wdata = 8'h5A;
        cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
        vm[16] = 8'h5A;
        cpu_rd = 1'b1;
        ppu_addr = 16'h8010;
        tick();
        cpu_rd = 1'b0;
        tests++;
        if (cpu_rdata !== 8'h5A) begin
            fails++;
            $display("FAIL vram_cpu_read got %h want 5a", cpu_rdata);
        end
        tests++;
        if (ppu_rdata !== 8'h5A) begin
            fails++;
            $display("FAIL vram_ppu_read got %h want 5a", ppu_rdata);
        end
    endtask

    task automatic test_draw_lock();
        lcd_on = 1'b1;
        ppu_mode = 2'd3;
        cpu_addr = 16'h8010;
        cpu_wdata = 8'h11;
        cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
        cpu_rd = 1'b1;
        ppu_addr = 16'h8010;
        tick();
        cpu_rd = 1'b0;
        tests++;
        if (cpu_rdata !== 8'hFF) begin
            fails++;
            $display("FAIL draw_cpu_read got %h want ff", cpu_rdata);
        end
        tests++;
        if (ppu_rdata !== vm[16]) begin
            fails++;
            $display("FAIL draw_ppu_read got %h want %h", ppu_rdata, vm[16]);
        end
        ppu_mode = 2'd2;
        cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
        vm[16] = 8'h11;
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        tests++;
        if (cpu_rdata !== 8'h11) begin
            fails++;
            $display("FAIL scan_vram_read got %h want 11", cpu_rdata);
        end
        tick();
        tests++;
        if (cpu_rdata !== 8'h11) begin
            fails++;
            $display("FAIL cpu_rdata_hold got %h want 11", cpu_rdata);
        end
    endtask

    task automatic test_oam_lock();
        lcd_on = 1'b1;
        ppu_mode = 2'd0;
        cpu_addr = 16'hFE00;
        cpu_wdata = 8'h44;
        cpu_wr = 1'b1;
        tick();
        ppu_mode = 2'd2;
        cpu_wdata = 8'h33;
        tick();
        cpu_wr = 1'b0;
        cpu_rd = 1'b1;
        tick();
        tests++;
        if (cpu_rdata !== 8'hFF) begin
            fails++;
            $display("FAIL oam_locked_read got %h want ff", cpu_rdata);
        end
        ppu_mode = 2'd0;
        tick();
        cpu_rd = 1'b0;
        tests++;
        if (cpu_rdata !== 8'h44) begin
            fails++;
            $display("FAIL oam_hblank_read got %h want 44", cpu_rdata);
        end
    endtask

    task automatic test_dma();
        int n;
        lcd_on = 1'b0;
        ppu_addr = 16'hFE05;
        cpu_addr = 16'hFF46;
        cpu_wdata = 8'hC1;
        cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
        n = 0;
        while (dma_active === 1'b1 && n < 400) begin
            tests++;
            if (n < 160) begin
                if (dma_src_rd !== 1'b1 ||
                    dma_src_addr !== 16'hC100 + 16'(n)) begin
                    fails++;
                    $display("FAIL dma_src cyc %0d got rd=%b a=%h want 1 %h",
                             n, dma_src_rd, dma_src_addr, 16'hC100 + 16'(n));
                end
            end else if (dma_src_rd !== 1'b0) begin
                fails++;
                $display("FAIL dma_src_rd_tail got %b want 0", dma_src_rd);
            end
            if (n >= 1) begin
                tests++;
                if (ppu_rdata !== 8'hFF) begin
                    fails++;
                    $display("FAIL dma_ppu_oam cyc %0d got %h want ff",
                             n, ppu_rdata);
                end
            end
            tick();
            n++;
        end
        tests++;
        if (n != 161) begin
            fails++;
            $display("FAIL dma_active_len got %0d want 161", n);
        end
        for (int k = 0; k < 160; k++) om[k] = 8'(k) ^ 8'hA5;
        for (int k = 0; k < 160; k++) begin
            ppu_addr = 16'hFE00 + 16'(k);
            tick();
            tests++;
            if (ppu_rdata !== om[k]) begin
                fails++;
                $display("FAIL dma_oam[%0d] got %h want %h",
                         k, ppu_rdata, om[k]);
            end
        end
    endtask

    task automatic test_restart();
        int n;
        cpu_addr = 16'hFF46;
        cpu_wdata = 8'hC1;
        cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
        n = 0;
        while (dma_active === 1'b1 && n < 600) begin
            n++;
            if (n == 50) begin
                cpu_wdata = 8'hC2;
                cpu_wr = 1'b1;
            end
            tick();
            if (n == 50) begin
                cpu_wr = 1'b0;
                tests++;
                if (dma_src_rd !== 1'b1 || dma_src_addr !== 16'hC200) begin
                    fails++;
                    $display("FAIL restart_addr got rd=%b a=%h want 1 c200",
                             dma_src_rd, dma_src_addr);
                end
            end
        end
        tests++;
        if (n != 211) begin
            fails++;
            $display("FAIL restart_len got %0d want 211", n);
        end
    endtask

    task automatic test_reset_abort();
        cpu_addr = 16'hFF46;
        cpu_wdata = 8'hC3;
        cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
        repeat (20) tick();
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (dma_active !== 1'b0 || dma_src_rd !== 1'b0 ||
            dma_src_addr !== 16'h0000) begin
            fails++;
            $display("FAIL reset_abort got act=%b rd=%b a=%h want 0 0 0000",
                     dma_active, dma_src_rd, dma_src_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] p;
        logic [7:0]  d;
        logic [7:0]  exp_c;
        logic [7:0]  exp_p;
        int          off;
        lcd_on = 1'b0;
        for (int k = 0; k < 64; k++) begin
            for (int h = 0; h < 2; h++) begin
                a = (h == 0) ? 16'h8000 + 16'(k) : 16'h9FC0 + 16'(k);
                d = 8'($urandom);
                cpu_addr = a;
                cpu_wdata = d;
                cpu_wr = 1'b1;
                tick();
                vm[int'(a) - 32'h8000] = d;
            end
        end
        cpu_wr = 1'b0;
        exp_c = cpu_rdata;
        for (int t = 0; t < 400; t++) begin
            a = pick_addr();
            p = pick_addr();
            d = 8'($urandom);
            lcd_on = 1'($urandom);
            ppu_mode = 2'($urandom);
            cpu_addr = a;
            ppu_addr = p;
            cpu_wdata = d;
            cpu_rd = 1'($urandom);
            cpu_wr = ($urandom_range(0, 2) == 0);
            exp_p = model_ppu(p);
            if (cpu_rd) exp_c = model_cpu(a, lcd_on, ppu_mode);
            if (cpu_wr && model_cpu(a, lcd_on, ppu_mode) !== 8'hFF) begin
                off = int'(a) - 32'h8000;
                if (off >= 0 && off < 8192) vm[off] = d;
                else om[int'(a) - 32'hFE00] = d;
            end else if (cpu_wr && !(lcd_on && ppu_mode >= 2'd2)) begin
                off = int'(a) - 32'hFE00;
                if (off >= 0 && off < 160) om[off] = d;
                off = int'(a) - 32'h8000;
                if (off >= 0 && off < 8192 && !(lcd_on && ppu_mode == 2'd3))
                    vm[off] = d;
            end
            tick();
            tests++;
            if (cpu_rdata !== exp_c) begin
                fails++;
                $display("FAIL rand_cpu t=%0d a=%h got %h want %h",
                         t, a, cpu_rdata, exp_c);
            end
            tests++;
            if (ppu_rdata !== exp_p) begin
                fails++;
                $display("FAIL rand_ppu t=%0d a=%h got %h want %h",
                         t, p, ppu_rdata, exp_p);
            end
        end
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    task automatic test_collision();
        logic [7:0] old;
        lcd_on = 1'b0;
        ppu_mode = 2'd0;
        old = vm[8191];
        cpu_addr = 16'h9FFF;
        ppu_addr = 16'h9FFF;
        cpu_wdata = (old == 8'h77) ? 8'h78 : 8'h77;
        cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
        vm[8191] = cpu_wdata;
        tests++;
        if (ppu_rdata !== old) begin
            fails++;
            $display("FAIL collision_old got %h want %h", ppu_rdata, old);
        end
        tick();
        tests++;
        if (ppu_rdata !== vm[8191]) begin
            fails++;
            $display("FAIL collision_new got %h want %h", ppu_rdata, vm[8191]);
        end
        ppu_addr = 16'hFEA0;
        cpu_addr = 16'hFF46;
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        tests++;
        if (ppu_rdata !== 8'hFF) begin
            fails++;
            $display("FAIL ppu_oob got %h want ff", ppu_rdata);
        end
        tests++;
        if (cpu_rdata !== 8'hFF) begin
            fails++;
            $display("FAIL cpu_reg_read got %h want ff", cpu_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_vram_rw();
        test_draw_lock();
        test_oam_lock();
        test_dma();
        test_restart();
        test_reset_abort();
        test_random();
        test_collision();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ppu_vram_responder.md
# ppu_vram_responder

Memory-side responder for the PPU fetch port and the CPU's VRAM/OAM accesses. It owns the 8 KiB VRAM array (0x8000–0x9FFF) and the 160-byte OAM array (0xFE00–0xFE9F). It answers PPU address requests with fixed one-cycle read data and arbitrates CPU access according to the PPU mode. It also runs the OAM DMA engine triggered by CPU writes to 0xFF46.

## Interface
Parameters:
- VRAM_BASE, 16'h8000, first VRAM address; VRAM spans 8192 bytes
- OAM_BASE, 16'hFE00, first OAM address; OAM spans 160 bytes
- DMA_REG, 16'hFF46, CPU write address that starts OAM DMA
- DMA_LEN, 160, bytes copied per DMA

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- lcd_on  in  1  LCDC bit 7; when 0, no mode-based CPU lockout
- ppu_mode  in  2  0 H_BLANK, 1 V_BLANK, 2 SCAN, 3 DRAW
- ppu_addr  in  16  PPU fetch address, sampled every cycle
- ppu_rdata  out  8  data for the ppu_addr sampled on the previous edge
- cpu_addr  in  16  CPU bus address
- cpu_rd  in  1  CPU read strobe
- cpu_wr  in  1  CPU write strobe
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  registered CPU read data
- dma_src_rd  out  1  DMA source read strobe to the system bus
- dma_src_addr  out  16  DMA source address
- dma_src_data  in  8  system-bus data for the dma_src_addr of the previous cycle
- dma_active  out  1  high while DMA owns OAM

## Operation
- **PPU port**
  - No strobe; the port is serviced every cycle.
  - ppu_rdata <= VRAM[ppu_addr−VRAM_BASE] when ppu_addr is in VRAM.
  - ppu_rdata <= OAM[ppu_addr−OAM_BASE] when ppu_addr is in OAM and dma_active=0.
  - Otherwise ppu_rdata <= 8'hFF.
  - The PPU is never blocked.
- **CPU port**
  - VRAM is locked when lcd_on && ppu_mode==3.
  - OAM is locked when dma_active, or when lcd_on && ppu_mode∈{2,3}.
  - Locked access: writes are dropped and reads return 8'hFF.
  - Unlocked in-range write with cpu_wr=1: the array is written at the edge.
  - cpu_rdata <= array byte on cpu_rd for an unlocked in-range address; 8'hFF otherwise. It holds its value when cpu_rd=0.
  - Any other address reads 8'hFF; register space belongs to the PPU register file.
- **Same-address collision:** a PPU read and a CPU or DMA write in the same cycle returns the old byte (read-before-write).
- **DMA state machine: IDLE / RUN**
  - IDLE→RUN: cpu_wr at DMA_REG latches src_hi=cpu_wdata and clears index i to 0. The write is never blocked.
  - RUN, per cycle:
    - dma_src_rd=1 and dma_src_addr={src_hi, i[7:0]} while i<160.
    - OAM[i−1] <= dma_src_data for i≥1.
    - i increments each cycle.
  - RUN→IDLE: after the write of OAM[159], i.e. once the increment makes i=161.
  - A DMA_REG write during RUN restarts at i=0 with the new src_hi. Bytes already copied stay in OAM.
  - src_hi is used unmodified; there is no address clamp.
- **Width rules**
  - Offsets are 13 bits for VRAM and 8 bits for OAM.
  - i is 8 bits and saturates; no wrap.
  - OAM range test is ppu_addr−OAM_BASE < 160.

## Timing
- **Reset values:** ppu_rdata=8'hFF, cpu_rdata=8'hFF, dma_active=0, dma_src_rd=0, dma_src_addr=16'h0000, DMA state IDLE, i=0. Array contents are not reset.
- **Reset mid-DMA:** aborts immediately. OAM keeps the bytes already written.
- **Read latency:** one cycle on both ports; data is valid the cycle after the address is presented.
- **Lock timing:** lock decisions use ppu_mode/lcd_on as sampled at the same edge as the access.
- **DMA timing**
  - dma_active rises the cycle after the DMA_REG write and stays high 161 cycles.
  - dma_src_rd is high for the first 160 of those cycles.
  - OAM[k] is written at the end of cycle k+1 of RUN.
- **Throughput:** one PPU read, one CPU access and one DMA write are possible per cycle.

## Test plan
- **VRAM write/read:** lcd_on=0; CPU writes 0x8010=0x5A, then cpu_rd 0x8010 → cpu_rdata=0x5A one cycle later. ppu_addr=0x8010 → ppu_rdata=0x5A the next cycle.
- **DRAW lockout:** lcd_on=1, ppu_mode=3. CPU writes 0x8010=0x11 → VRAM is unchanged (PPU reads 0x5A); cpu_rd 0x8010 → 0xFF. Same with ppu_mode=2 → write lands and reads back 0x11.
- **OAM lockout:** ppu_mode=2 → CPU write to 0xFE00 is dropped and reads 0xFF. ppu_mode=0 → the write lands.
- **DMA:**
  - Stimulus: CPU writes 0xFF46=0xC1; source model returns low address byte XOR 0xA5.
  - dma_active high exactly 161 cycles.
  - dma_src_addr steps 0xC100..0xC19F.
  - Afterwards, PPU reads of 0xFE00..0xFE9F return i^0xA5.
- **DMA restart and reset abort:**
  - Restart: write 0xFF46=0xC2 at RUN cycle 50 → index restarts at 0, dma_src_addr=0xC200, total active 50+161 cycles.
  - Reset abort: assert rst mid-DMA → dma_active=0 asynchronously.
- **Collision and out of range:**
  - CPU write 0x9FFF=0x77 while ppu_addr=0x9FFF → ppu_rdata=old value that cycle, 0x77 the next.
  - ppu_addr=0xFEA0 → 0xFF.
